// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake, a stored carry flag and a multi-cycle shift-add multiply
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     operation request
//   in_ready_o     high only in IDLE; accept = in_valid_i && in_ready_o
//   op_i           000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MUL
//   a_i, b_i       operands, sampled on accept
//   out_valid_o    result and flags valid (DONE state)
//   out_ready_i    consumer takes the result
//   result_o       registered result
//   cout_o         carry out, also the stored carry flag C used by ADC/SBC
//   zero_o         result_o == 0
//   negative_o     result_o MSB
//   overflow_o     signed overflow (MUL: high half of the product non-zero)
module seq_alu #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           op_i,
    input  logic [DATA_BITS-1:0] a_i,
    input  logic [DATA_BITS-1:0] b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] result_o,
    output logic                 cout_o,
    output logic                 zero_o,
    output logic                 negative_o,
    output logic                 overflow_o
);
    localparam int W  = DATA_BITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   result_q, result_d, mplier_q, mplier_d;
    logic           c_q, c_d, v_q, v_d;
    logic [2*W-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_sum;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   b_x, logic_r;
    logic [W:0]     sum;
    logic           cin, add_v, hi_nz;

    always_comb begin
        // op_i[0] selects subtraction (b inverted); op_i[1] selects the stored carry as carry-in
        b_x     = op_i[0] ? ~b_i : b_i;
        cin     = op_i[1] ? c_q : op_i[0];
        sum     = {1'b0, a_i} + {1'b0, b_x} + {{W{1'b0}}, cin};
        add_v   = (a_i[W-1] == b_x[W-1]) && (sum[W-1] != a_i[W-1]);
        logic_r = (op_i[1:0] == 2'b00) ? (a_i & b_i) : (op_i[1:0] == 2'b01) ? (a_i | b_i) : (a_i ^ b_i);
        acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;
        hi_nz   = |acc_sum[2*W-1:W];
        state_d  = state_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && op_i == 3'b111) begin
                    mcand_d  = {{W{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = CW'(W);
                    state_d  = S_MUL;
                end else if (in_valid_i) begin
                    // logic ops (op_i[2]) clear both carry and overflow
                    result_d = op_i[2] ? logic_r : sum[W-1:0];
                    c_d      = !op_i[2] && sum[W];
                    v_d      = !op_i[2] && add_v;
                    state_d  = S_DONE;
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = acc_sum[W-1:0];
                    c_d      = hi_nz;
                    v_d      = hi_nz;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = out_ready_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign cout_o      = c_q;
    assign overflow_o  = v_q;
    assign zero_o      = (result_q == '0);
    assign negative_o  = result_q[W-1];
endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential, parametrised ALU for the datapath. It accepts one operation at a time through a valid/ready handshake and returns a registered result with a full flag set. The flag set is carry, zero, negative and overflow. A stored carry flag supports multi-word ADC/SBC chains, and MUL is executed as a multi-cycle shift-add. It replaces the combinational add/sub unit between the register file read ports and the write-back stage.

## Interface
- DATA_BITS, 8: operand and result width (≥2).
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- op  input  3  000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 MUL.
- a, b  input  DATA_BITS  operands, sampled on accept.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- result  output  DATA_BITS  registered result.
- cout  output  1  carry out; this is also the stored carry flag C.
- zero  output  1  result == 0 (cout not included).
- negative  output  1  result[DATA_BITS-1].
- overflow  output  1  signed overflow.

## Operation
- **FSM states: IDLE, MUL, DONE.**
  - IDLE: in_ready=1. Accept = in_valid && in_ready.
    - Non-MUL op on accept: compute and register result and flags, then go to DONE.
    - MUL on accept: load mcand = {0, a} (2·DATA_BITS wide), mplier = b, acc = 0, cnt = DATA_BITS; go to MUL.
  - MUL: each cycle, if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; cnt -= 1.
    - When the cycle with cnt==1 completes, register result = acc[DATA_BITS-1:0] and flags, then go to DONE.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE.
- **Arithmetic.** All sums are computed DATA_BITS+1 wide; cout is the MSB.
  - ADD: a+b.
  - SUB: a+~b+1. cout=1 means no borrow (a ≥ b unsigned).
  - ADC: a+b+C.
  - SBC: a+~b+C.
  - overflow (ADD/ADC/SUB/SBC) = (a[msb] == b'[msb]) && (result[msb] != a[msb]), where b' is b for ADD/ADC and ~b for SUB/SBC.
- **Logic ops (AND/OR/XOR):** cout=0, overflow=0.
- **MUL:** unsigned. result = low half of the product. cout = overflow = |acc[2·DATA_BITS-1:DATA_BITS].
- **Stored carry C** is the cout register. Every completed operation updates it, including logic ops (cleared to 0). ADC/SBC read the C value present at accept.
- **zero and negative** derive from the registered result for every op.

## Timing
- **Reset (async, reset_n low):**
  - state=IDLE.
  - in_ready=1 once reset releases.
  - out_valid=0, result=0, cout=0, zero=1, negative=0, overflow=0.
  - acc, mcand, mplier and cnt are cleared.
  - A reset during MUL or DONE discards the operation; no out_valid follows.
- **Non-MUL latency:** accept at edge k, out_valid high after edge k+1.
- **MUL latency:** accept at edge k, out_valid high after edge k+DATA_BITS+1.
- **Output hold:** result and flags do not change while out_valid=1 && out_ready=0.
- **Release:** out_valid drops after the edge where out_valid && out_ready. in_ready rises on that same edge.
- **Throughput:** one op per 2 cycles minimum (non-MUL), with out_ready tied high.
- **Ignored inputs:** in_valid while in_ready=0 is ignored; the request must be held by the producer. Changes to op, a or b after accept have no effect.
- **Early out_ready:** out_ready asserted before out_valid has no effect.

## Test plan
- **Reset:** assert reset_n=0 mid-MUL (DATA_BITS=8, 200×3, cycle 4) → out_valid=0, result=0x00, zero=1, cout=0; next accept proceeds normally.
- **ADD/SUB/overflow:** ADD 0x7F+0x01 → result 0x80, negative=1, overflow=1, cout=0 at cycle k+1. SUB 0x05−0x05 → 0x00, zero=1, cout=1.
- **Carry chain:** ADD 0xFF+0x01 (result 0x00, cout=1, zero=1), then ADC 0x00+0x00 → 0x01, cout=0. SUB 0x00−0x01 (0xFF, cout=0), then SBC 0x10−0x00 → 0x0F.
- **MUL:**
  - 15×17 → result 0xFF, cout=0, out_valid exactly 9 cycles after accept.
  - 200×3 → result 0x58, cout=1, overflow=1.
  - 0×anything → zero=1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid → result and flags are stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 → next cycle out_valid=0 and in_ready=1.
- **Logic ops and parameter sweep:** AND 0xF0&0x3C=0x30, OR=0xFC, XOR=0xCC, each with cout=0 (clearing C). Repeat randomised ops against a reference model for DATA_BITS = 4, 8, 16.
